// File: rtl/bcd_counter_display.sv
// -----------------------------------------------------------------------------
// bcd_counter_display
//   N-digit BCD up/down counter driven by two raw push-buttons, with a
//   self-scanning, time-multiplexed active-low 7-segment display driver.
//
//   Each button passes through a 2-FF synchroniser, a debouncer and a rising
//   edge detector.  The resulting one-cycle press pulses step the BCD count
//   by one; simultaneous inc/dec pulses cancel.  The scanner holds each digit
//   for SCAN_DIV cycles and drives registered seg/sel outputs.
//
//   Parameters:
//     DIGITS          number of BCD digits counted and displayed (1..8)
//     DEBOUNCE_CYCLES stable cycles before a button level is accepted (>=2)
//     SCAN_DIV        cycles each digit is held active (>=2)
//
//   Ports:
//     clk      system clock, rising edge
//     rst      asynchronous active-high reset
//     btn_inc  raw increment button, active-high, asynchronous
//     btn_dec  raw decrement button, active-high, asynchronous
//     value    packed BCD count, value[3:0] = least significant digit
//     seg      segment cathodes, active-low, {g,f,e,d,c,b,a}
//     sel      digit enables, active-low one-hot, sel[0] = least significant
//
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, leading zero digits (index > 0)
//                            are blanked; digit 0 always shows.
// -----------------------------------------------------------------------------
module bcd_counter_display #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SCAN_DIV        = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  output logic [4*DIGITS-1:0]   value,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     sel
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ---------------------------------------------------------------------------
  // Input conditioning: index 0 = inc, index 1 = dec
  // ---------------------------------------------------------------------------
  logic [1:0]      btn_raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db_level;
  logic [1:0]      db_level_q;
  logic [DB_W-1:0] db_cnt [2];
  logic            inc_pulse;
  logic            dec_pulse;

  assign btn_raw = {btn_dec, btn_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      db_level   <= '0;
      db_level_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      db_level_q <= db_level;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign inc_pulse = db_level[0] & ~db_level_q[0];
  assign dec_pulse = db_level[1] & ~db_level_q[1];

  // ---------------------------------------------------------------------------
  // BCD counter with ripple carry / borrow across digits
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] val_inc;
  logic [4*DIGITS-1:0] val_dec;
  logic                carry;
  logic                borrow;

  always_comb begin
    val_inc = value;
    val_dec = value;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          val_inc[4*i +: 4] = 4'd0;
        end else begin
          val_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (value[4*i +: 4] == 4'd0) begin
          val_dec[4*i +: 4] = 4'd9;
        end else begin
          val_dec[4*i +: 4] = value[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (inc_pulse && !dec_pulse) begin
      value <= val_inc;
    end else if (dec_pulse && !inc_pulse) begin
      value <= val_dec;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scanner
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic [3:0]        cur_digit;
  logic              cur_blank;

  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Digit select is a compare-mux rather than a variable part-select so that
  // a non-power-of-two DIGITS never indexes past the end of value.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == scan_idx) begin
        cur_digit = value[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and all more-significant digits are zero.
        cur_blank = (i != 0) && ((value >> (4*i)) == '0);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg      <= 7'h7F;
      sel      <= '1;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        if (scan_idx == IDX_W'(DIGITS - 1)) begin
          scan_idx <= '0;
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      sel <= ~(DIGITS'(1) << scan_idx);
      seg <= cur_blank ? 7'h7F : ~decode7(cur_digit);
    end
  end

endmodule
